// File: rtl/act_grad_stream_pkg.sv
// Shared types and constants for the piecewise-linear activation gradient stream.
// Thresholds are returned in 32-bit signed so they never overflow narrow data widths.
package act_grad_pkg;

  localparam logic [1:0] MODE_LRELU = 2'd0;
  localparam logic [1:0] MODE_SIG3  = 2'd1;
  localparam logic [1:0] MODE_TANH5 = 2'd2;
  localparam logic [1:0] MODE_PASS  = 2'd3;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef enum logic [2:0] {SEL_ZERO, SEL_G, SEL_HALF, SEL_QUARTER, SEL_SLOPE} sel_t;

  function automatic logic signed [31:0] thr_two(input int unsigned frac);
    return 32'sd2 <<< frac;
  endfunction

  function automatic logic signed [31:0] thr_q1(input int unsigned frac);
    return 32'sd1 <<< (frac - 2);
  endfunction

  function automatic logic signed [31:0] thr_q3(input int unsigned frac);
    return 32'sd3 <<< (frac - 2);
  endfunction

endpackage

// File: rtl/act_grad_stream_if.sv
// Input pair stream and output gradient stream of act_grad_stream.
interface act_grad_stream_if #(parameter int WIDTH = 16);
  logic                    s_valid;
  logic                    s_ready;
  logic signed [WIDTH-1:0] s_x;
  logic signed [WIDTH-1:0] s_grad;
  logic                    m_valid;
  logic                    m_ready;
  logic signed [WIDTH-1:0] m_grad;
  logic                    m_last;

  modport slave  (input  s_valid, s_x, s_grad, m_ready,
                  output s_ready, m_valid, m_grad, m_last);
  modport master (output s_valid, s_x, s_grad, m_ready,
                  input  s_ready, m_valid, m_grad, m_last);
endinterface

// File: rtl/act_grad_stream_core.sv
// Combinational region classification of x and the multiply/shift/saturate of g.
module act_grad_core
  import act_grad_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8
) (
  input  logic [1:0]              mode,
  input  logic signed [WIDTH-1:0] x,
  output sel_t                    sel,
  input  sel_t                    sel_r,
  input  logic signed [WIDTH-1:0] g,
  input  logic signed [WIDTH-1:0] slope,
  output logic signed [WIDTH-1:0] y
);
  localparam logic signed [WIDTH-1:0]   XMIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0]   YMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [2*WIDTH-1:0] PMAX = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [2*WIDTH-1:0] PMIN = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic signed [31:0] T_TWO = thr_two(FRAC);
  localparam logic signed [31:0] T_Q1  = thr_q1(FRAC);
  localparam logic signed [31:0] T_Q3  = thr_q3(FRAC);

  logic signed [31:0]        ax;
  logic                      inner;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [2*WIDTH-1:0] scaled;

  // The most negative x has no representable magnitude and is kept out of every inner segment.
  always_comb begin
    ax    = x[WIDTH-1] ? -32'(x) : 32'(x);
    inner = (x != XMIN);
    sel   = SEL_ZERO;
    case (mode)
      MODE_LRELU: sel = (!x[WIDTH-1] && x != '0) ? SEL_G : SEL_SLOPE;
      MODE_SIG3:  if (inner && ax <= T_TWO) sel = SEL_QUARTER;
      MODE_TANH5: begin
        if (inner && ax <= T_Q1)     sel = SEL_G;
        else if (inner && ax < T_Q3) sel = SEL_HALF;
      end
      default:    sel = SEL_G;
    endcase
  end

  always_comb begin
    prod   = {{WIDTH{slope[WIDTH-1]}}, slope} * {{WIDTH{g[WIDTH-1]}}, g};
    scaled = prod >>> FRAC;
    y      = '0;
    case (sel_r)
      SEL_G:       y = g;
      SEL_HALF:    y = g >>> 1;
      SEL_QUARTER: y = g >>> 2;
      SEL_SLOPE: begin
        if (scaled > PMAX)      y = YMAX;
        else if (scaled < PMIN) y = XMIN;
        else                    y = scaled[WIDTH-1:0];
      end
      default:     y = '0;
    endcase
  end
endmodule

// File: rtl/act_grad_stream.sv
// Burst controller and 2-stage pipeline emitting dL/dx = f'(x)*g for
// piecewise-linear activations.
module act_grad_stream
  import act_grad_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8,
  parameter int LEN_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [1:0]              cfg_mode,
  input  logic signed [WIDTH-1:0] cfg_slope,
  input  logic [LEN_W-1:0]        cfg_len,
  act_grad_stream_if.slave        bus,
  output logic                    busy,
  output logic                    done
);
  state_t                  state_q, state_d;
  logic [LEN_W-1:0]        cnt_q, len_q;
  logic [1:0]              mode_q;
  logic signed [WIDTH-1:0] slope_q;
  logic                    done_q;
  logic                    v1_q, last1_q, v2_q, last2_q;
  sel_t                    sel1_q, sel_in;
  logic signed [WIDTH-1:0] g1_q, y2_q, y_c;
  logic                    adv1, adv2, s_fire, m_fire, acc_last, start_ok;

  assign adv2      = !v2_q || bus.m_ready;
  assign adv1      = !v1_q || adv2;
  assign bus.s_ready = (state_q == RUN) && (cnt_q < len_q) && adv1;
  assign s_fire    = bus.s_valid && bus.s_ready;
  assign m_fire    = v2_q && bus.m_ready;
  assign acc_last  = s_fire && (cnt_q == len_q - 1'b1);
  assign start_ok  = (state_q == IDLE) && start;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && cfg_len != '0) state_d = RUN;
      RUN:     if (acc_last) state_d = DRAIN;
      DRAIN:   if (m_fire && last2_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      mode_q  <= '0;
      slope_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (start_ok && cfg_len == '0) || (state_q == DRAIN && m_fire && last2_q);
      if (start_ok) begin
        mode_q  <= cfg_mode;
        slope_q <= cfg_slope;
        len_q   <= cfg_len;
        cnt_q   <= '0;
      end else if (s_fire) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Each stage loads when its successor is empty or draining, giving one element per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      last1_q <= 1'b0;
      g1_q    <= '0;
      sel1_q  <= SEL_ZERO;
      v2_q    <= 1'b0;
      last2_q <= 1'b0;
      y2_q    <= '0;
    end else begin
      if (adv1) begin
        v1_q    <= s_fire;
        last1_q <= acc_last;
        if (s_fire) begin
          g1_q   <= bus.s_grad;
          sel1_q <= sel_in;
        end
      end
      if (adv2) begin
        v2_q    <= v1_q;
        last2_q <= last1_q;
        if (v1_q) y2_q <= y_c;
      end
    end
  end

  act_grad_core #(.WIDTH(WIDTH), .FRAC(FRAC)) u_core (
    .mode  (mode_q),
    .x     (bus.s_x),
    .sel   (sel_in),
    .sel_r (sel1_q),
    .g     (g1_q),
    .slope (slope_q),
    .y     (y_c)
  );

  assign bus.m_valid = v2_q;
  assign bus.m_grad  = y2_q;
  assign bus.m_last  = last2_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
endmodule

// File: tb/tb_act_grad_stream.sv
// Self-checking bench for act_grad_stream: vector table, hand sequences and
// randomized bursts against a behavioural derivative model.
module tb_act_grad_stream;
  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic [1:0]         cfg_mode;
  logic signed [15:0] cfg_slope;
  logic [15:0]        cfg_len;
  logic               busy;
  logic               done;

  act_grad_stream_if #(.WIDTH(16)) bus ();

  act_grad_stream #(.WIDTH(16), .FRAC(8), .LEN_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cfg_mode  (cfg_mode),
    .cfg_slope (cfg_slope),
    .cfg_len   (cfg_len),
    .bus       (bus),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mode;
    int slope;
    int x;
    int g;
    int exp;
  } vec_t;

  vec_t tbl[14];
  int   edge_x[16] = '{-32768, -513, -512, -192, -191, -65, -64, 0,
                       1, 64, 65, 191, 192, 512, 513, 32767};

  int errors = 0;
  int checks = 0;

  logic signed [15:0] xs[$];
  logic signed [15:0] gs[$];
  int                 exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Derivative of each activation times g, straight from the segment definitions.
  function automatic int ref_grad(input int mode, input int slope, input int x, input int g);
    int     ax;
    longint p;
    ax = (x < 0) ? -x : x;
    case (mode)
      0: begin
        if (x > 0) return g;
        p = longint'(slope) * longint'(g);
        p = p >>> 8;
        if (p > 32767) return 32767;
        if (p < -32768) return -32768;
        return int'(p);
      end
      1: return (ax <= 512) ? (g >>> 2) : 0;
      2: begin
        if (ax <= 64) return g;
        if (ax < 192) return g >>> 1;
        return 0;
      end
      default: return g;
    endcase
  endfunction

  // Runs one burst from the xs/gs/exp_q queues; called at a falling edge.
  task automatic run_burst(input int mode, input logic signed [15:0] slope, input int pv,
                           input int pr, input int stall_lo, input int stall_hi, input bit poke);
    int len, nin, nout, first_in, first_mv, exp_rdy;
    bit pend, fin;
    len = xs.size();
    start = 1'b1; cfg_mode = 2'(mode); cfg_slope = slope; cfg_len = 16'(len);
    @(negedge clk);
    start = 1'b0; cfg_mode = 2'($urandom); cfg_slope = 16'($urandom); cfg_len = 16'($urandom);
    #1 check("busy_after_start", busy, 1);
    nin = 0; nout = 0; first_in = -1; first_mv = -1; pend = 0; fin = 0;
    for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
      start = poke && (cyc == 1);
      if (start) cfg_len = 16'd2;
      bus.s_valid = (nin < len) && ($urandom_range(99) < pv);
      if (nin < len) begin
        bus.s_x    = xs[nin];
        bus.s_grad = gs[nin];
      end
      bus.m_ready = !(cyc >= stall_lo && cyc <= stall_hi) && ($urandom_range(99) < pr);
      #1;
      if (pend) begin
        check("done_pulse", done, 1);
        check("busy_drop", busy, 0);
        check("no_extra_out", bus.m_valid, 0);
        fin = 1;
      end else begin
        if (done) check("done_early", done, 0);
        exp_rdy = ((nin < len) && ((nin - nout) < 2 || bus.m_ready)) ? 1 : 0;
        check("s_ready", bus.s_ready, exp_rdy);
        if (bus.s_valid && bus.s_ready) begin
          if (first_in < 0) first_in = cyc;
          nin++;
        end
        if (bus.m_valid && first_mv < 0) first_mv = cyc;
        if (bus.m_valid && bus.m_ready) begin
          if (nout < len) begin
            check("m_grad", int'($signed(bus.m_grad)), exp_q[nout]);
            check("m_last", bus.m_last, (nout == len - 1) ? 1 : 0);
          end else begin
            check("extra_output", bus.m_valid, 0);
          end
          nout++;
          if (nout == len) pend = 1;
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;
    check("burst_complete", int'(fin), 1);
    check("out_count", nout, len);
    check("latency", first_mv - first_in, 2);
    xs.delete(); gs.delete(); exp_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int mode, len, x;
    logic signed [15:0] slope;

    tbl[0]  = '{0, 32767, -1, 32767, 32767};
    tbl[1]  = '{0, 32767, -1, -32768, -32768};
    tbl[2]  = '{1, 0, 512, 400, 100};
    tbl[3]  = '{1, 0, 513, 400, 0};
    tbl[4]  = '{1, 0, -512, -400, -100};
    tbl[5]  = '{1, 0, 0, -3, -1};
    tbl[6]  = '{2, 0, 64, 300, 300};
    tbl[7]  = '{2, 0, 65, 300, 150};
    tbl[8]  = '{2, 0, -100, 300, 150};
    tbl[9]  = '{2, 0, 192, 300, 0};
    tbl[10] = '{2, 0, -32768, 300, 0};
    tbl[11] = '{3, 0, -5, -123, -123};
    tbl[12] = '{0, 64, 100, -7, -7};
    tbl[13] = '{0, -128, -3, 7, -4};

    rst_n = 1'b0; start = 1'b0; cfg_mode = '0; cfg_slope = '0; cfg_len = '0;
    bus.s_valid = 1'b0; bus.s_x = '0; bus.s_grad = '0; bus.m_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_s_ready", bus.s_ready, 0);
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_m_grad", int'($signed(bus.m_grad)), 0);
    check("rst_m_last", bus.m_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // LReLU burst of three with the final element tagged last
    xs = '{-16'sd512, 16'sd300, 16'sd0};
    gs = '{16'sd400, -16'sd77, 16'sd256};
    exp_q = '{100, -77, 64};
    run_burst(0, 16'sd64, 100, 100, 1, 0, 0);

    for (int i = 0; i < 14; i++) begin
      xs.push_back(16'(tbl[i].x));
      gs.push_back(16'(tbl[i].g));
      exp_q.push_back(tbl[i].exp);
      run_burst(tbl[i].mode, 16'(tbl[i].slope), 100, 100, 1, 0, 0);
    end

    // Backpressure: m_ready low for cycles 3..5 with continuous input
    for (int i = 0; i < 8; i++) begin
      xs.push_back(16'(edge_x[$urandom_range(15)]));
      gs.push_back(16'($urandom));
      exp_q.push_back(ref_grad(2, 0, xs[i], gs[i]));
    end
    run_burst(2, 16'sd0, 100, 100, 3, 5, 0);

    // Zero-length burst
    start = 1'b1; cfg_mode = 2'd3; cfg_len = 16'd0;
    @(negedge clk);
    start = 1'b0; bus.m_ready = 1'b1;
    #1;
    check("len0_done", done, 1);
    check("len0_busy", busy, 0);
    check("len0_m_valid", bus.m_valid, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("len0_done_once", done, 0);
      check("len0_no_output", bus.m_valid, 0);
    end
    bus.m_ready = 1'b0;
    @(negedge clk);

    // Start pulse mid-burst must not restart or shorten the burst
    for (int i = 0; i < 5; i++) begin
      xs.push_back(16'($urandom));
      gs.push_back(16'($urandom));
      exp_q.push_back(ref_grad(1, 0, xs[i], gs[i]));
    end
    run_burst(1, 16'sd0, 100, 60, 1, 0, 1);
    #1 check("start_ignored_idle", busy, 0);
    @(negedge clk);

    // Reset in the middle of a stalled burst
    start = 1'b1; cfg_mode = 2'd3; cfg_len = 16'd6;
    @(negedge clk);
    start = 1'b0;
    bus.m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.s_valid = 1'b1; bus.s_x = 16'sd10; bus.s_grad = 16'(100 + i);
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
    #1 check("pre_reset_m_valid", bus.m_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_m_valid", bus.m_valid, 0);
    check("mid_rst_m_grad", int'($signed(bus.m_grad)), 0);
    check("mid_rst_m_last", bus.m_last, 0);
    check("mid_rst_s_ready", bus.s_ready, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("post_rst_no_done", done, 0);
      check("post_rst_no_output", bus.m_valid, 0);
    end
    bus.m_ready = 1'b0;
    @(negedge clk);

    // Randomized bursts
    for (int b = 0; b < 25; b++) begin
      mode  = $urandom_range(3);
      slope = 16'($urandom);
      len   = $urandom_range(1, 10);
      for (int i = 0; i < len; i++) begin
        x = ($urandom_range(1) == 1) ? edge_x[$urandom_range(15)] : int'($signed(16'($urandom)));
        xs.push_back(16'(x));
        gs.push_back(16'($urandom));
        exp_q.push_back(ref_grad(mode, slope, xs[i], gs[i]));
      end
      run_burst(mode, slope, $urandom_range(50, 100), $urandom_range(50, 100), 1, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/act_grad_stream.md
Name: act_grad_stream

Overview:
- Backward-pass counterpart of the team's piecewise-linear activation blocks (leaky ReLU, 3-segment hard sigmoid, 5-segment tanh).
- Streams pairs of (saved pre-activation x, upstream gradient g) and emits dL/dx = f'(x)·g in the same signed fixed-point format.
- Sits between the loss/gradient path and the weight-update engine of the GAN training datapath.
- Each burst has a programmed length with a valid/ready handshake on both sides.

Parameters:
- WIDTH, 16, total signed data width.
- FRAC, 8, fractional bits (Q(WIDTH-FRAC).FRAC); 1.0 = 1<<FRAC.
- LEN_W, 16, width of burst length and element counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; starts a burst when idle.
- cfg_mode  in  2  0=LReLU, 1=sigmoid3, 2=tanh5, 3=pass-through; sampled on accepted start.
- cfg_slope  in  WIDTH  LReLU negative slope, Q format; sampled on accepted start.
- cfg_len  in  LEN_W  elements in burst; sampled on accepted start.
- s_valid  in  1  input pair valid.
- s_ready  out  1  input pair accepted when s_valid&&s_ready.
- s_x  in  WIDTH  saved pre-activation value (signed).
- s_grad  in  WIDTH  upstream gradient (signed).
- m_valid  out  1  output gradient valid.
- m_ready  in  1  downstream ready.
- m_grad  out  WIDTH  f'(x)·g (signed).
- m_last  out  1  marks final element of burst, qualified by m_valid.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after last output handshake.

Behaviour:
- Reset: async on rst_n low. State=IDLE, counters 0, pipeline valids 0. s_ready, m_valid, m_grad, m_last, busy and done all 0.
- FSM:
  - IDLE: start → latch cfg and go to RUN. If cfg_len==0, pulse done next cycle instead and stay in IDLE.
  - RUN: s_ready = (accepted count < len) && pipeline can advance. The count-th accepted beat with count==len-1 is tagged last. Go to DRAIN after the last acceptance.
  - DRAIN: s_ready=0. On handshake of the tagged-last output, done=1 for one cycle and return to IDLE; busy drops the same cycle.
- start while busy is ignored. cfg_* changes during a burst have no effect.
- Pipeline: 2 stages, stage register per stage with valid bit.
  - Stage 1 registers x, g and the region/slope select.
  - Stage 2 registers the multiply/shift/saturate result into m_grad.
  - Stage advances when its successor is empty or taking its data. No bubbles at full throughput: 1 element/cycle with m_ready high, latency 2 cycles from input handshake to m_valid.
  - m_valid held and m_grad/m_last stable while m_ready=0. No loss, no duplication, order preserved.
- Derivatives (thresholds are constants scaled by FRAC; comparisons signed):
  - LReLU: x>0 → g. x<=0 → (cfg_slope·g)>>>FRAC, full 2·WIDTH product, then saturate to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
  - sigmoid3: |x|<=2.0 → g>>>2, else 0.
  - tanh5: |x|<=0.25 → g; 0.25<|x|<0.75 → g>>>1; |x|>=0.75 → 0.
  - pass-through: g.
- Rounding: arithmetic shift right (floor toward −inf), no rounding add.
- |x| computed without overflow: x = −2^(WIDTH−1) is treated as outside all inner segments.
- Reset mid-burst: all in-flight data discarded, no done pulse, returns to IDLE.

Decomposition:
- Package act_grad_pkg:
  - mode encoding constants MODE_LRELU/MODE_SIG3/MODE_TANH5/MODE_PASS.
  - FSM state typedef (IDLE, RUN, DRAIN).
  - threshold functions returning 2.0, 0.25, 0.75 scaled by FRAC for a given WIDTH.
- One sub-module act_grad_core: combinational region classification plus multiply/shift/saturate. The top holds FSM, counter and pipeline registers.

Test Plan (WIDTH=16, FRAC=8):
- LReLU, slope=64 (0.25), len=3, pairs (x,g) = (−512,400), (300,−77), (0,256) → m_grad 100, −77, 64. m_last on third, done one cycle after its handshake.
- LReLU saturation, slope=32767: (−1,32767) → 32767 and (−1,−32768) → −32768.
- sigmoid3: (512,400)→100, (513,400)→0, (−512,−400)→−100, (0,−3)→−1.
- tanh5: (64,300)→300, (65,300)→150, (−100,300)→150, (192,300)→0, (−32768,300)→0.
- Backpressure, len=8, s_valid always high, m_ready low cycles 3–5:
  - outputs in order with no loss or duplication.
  - s_ready drops while both stages are full.
  - first m_valid 2 cycles after first input handshake.
- Control corners:
  - start with cfg_len=0 → done next cycle, m_valid never asserted.
  - start during busy is ignored.
  - rst_n low mid-burst → all outputs 0 immediately, no done; a fresh burst afterwards completes correctly.
